swcap_phase_ctrl: RTL
=====================

// Module: swcap_phase_ctrl
// PURPOSE
// Two-phase non-overlapping phase controller for the 2:1 switched-capacitor converter.
// phi1 drives the input-charge/output switches; phi2 drives the flying-cap/ground switches.
// Inserts programmable dead time between phases.
// Regulates the output by pulse-skipping on a feedback comparator, with a forced refresh period.
// PARAMETERS
// PH_W      8   clocks per active phase (phi1 or phi2 high); >=1
// DT_W      1   dead-time clocks after each phase, both phases low; >=1
// MAX_SKIP  15  max consecutive skipped periods before a forced period; >=1
// CNT_W     8   width of executed-period counter
// PORTS
// clk         input   1      controller clock; all state changes on rising edge
// rstb        input   1      asynchronous active-low reset
// en          input   1      converter enable
// fb_low      input   1      comparator: 1 = output below target, conversion needed
// skip_en     input   1      1 = pulse-skipping allowed; 0 = free-running
// phi1        output  1      phase-1 switch control, registered
// phi2        output  1      phase-2 switch control, registered
// active      output  1      1 whenever state != IDLE
// skip_pulse  output  1      one-clock pulse on entry to each SKIP period
// cycle_cnt   output  CNT_W  count of completed executed periods; wraps at 2^CNT_W
// BEHAVIOUR
// Reset (rstb=0, async): state=IDLE; phi1=phi2=active=skip_pulse=0; cycle_cnt=0; skip_cnt=0.
// States: IDLE, PH1, DT1, PH2, DT2, SKIP. Phase counter ph_cnt drives the dwell in each state.
// IDLE: both phases low. en=1 at edge k -> PH1; phi1=1 after edge k.
// PH1: phi1=1 for exactly PH_W clocks -> DT1.
// DT1: both low for DT_W clocks -> PH2.
// PH2: phi2=1 for exactly PH_W clocks -> DT2.
// DT2: both low for DT_W clocks. On the last DT2 clock:
//   - cycle_cnt += 1 (wraps).
//   - skip_cnt = 0.
//   - Then decide the next state.
// Decision (last clock of DT2 or SKIP), evaluated in priority order:
//   1. en=0 -> IDLE.
//   2. skip_en=1 && fb_low=0 && skip_cnt<MAX_SKIP -> SKIP.
//   3. Otherwise -> PH1.
// SKIP: both low for 2*(PH_W+DT_W) clocks, i.e. one full period.
//   - skip_cnt += 1 on entry.
//   - skip_pulse=1 on the first SKIP clock only.
// Forced refresh: when skip_cnt==MAX_SKIP, the next decision executes a period even if fb_low=0.
// fb_low is sampled only at decision clocks. It is not sampled inside PH1..DT2.
// en=0 during PH1/DT1/PH2/DT2: the current period completes through DT2, then IDLE.
//   A half-completed charge transfer is never aborted.
// en=0 during SKIP: IDLE on the next edge; skip_cnt cleared.
// Invariants:
//   - phi1 & phi2 is never 1.
//   - Every phi edge is separated from the opposite phase's rising edge by >= DT_W clocks.
//   - Period length is 2*(PH_W+DT_W) clocks, both executed and skipped.
// Async reset mid-operation: phases drop to 0 immediately, without waiting for clk; all counters cleared.
// TESTING (PH_W=4, DT_W=1, MAX_SKIP=3, CNT_W=8)
// T1 reset release, en=1, skip_en=0:
//   -> phi1 high 4 clk, 1 low, phi2 high 4 clk, 1 low; 10-clk period.
//   -> cycle_cnt=1 after the first DT2.
// T2 overlap checker over 1000 random en/fb_low/skip_en clocks:
//   -> phi1&phi2 never 1; dead time always >=1 clk.
// T3 skip_en=1, fb_low=0 held:
//   -> 1 executed period, then 3 SKIP periods (3 skip_pulse, 30 clks both low), then 1 forced period; repeats.
// T4 fb_low 0->1 midway through a SKIP period:
//   -> that SKIP completes; next period executes; skip_cnt=0.
// T5 en drops on the 2nd clock of PH1:
//   -> PH1/DT1/PH2/DT2 complete, cycle_cnt+1, then IDLE; active=0.
//   en drops in SKIP -> IDLE next edge.
// T6 rstb=0 asserted mid-PH2:
//   -> phi2=0 without clk; after release cycle_cnt=0.
//   Counter wrap: 256 executed periods -> cycle_cnt returns to 0.

Source files
------------

// File: rtl/swcap_phase_ctrl.sv
// Two-phase non-overlapping phase controller for a 2:1 switched-capacitor
// converter. phi1 and phi2 are separated by programmable dead time. Output
// regulation is by pulse-skipping on a feedback comparator, and a forced
// refresh period runs after MAX_SKIP consecutive skips.
module swcap_phase_ctrl #(
  parameter int PH_W     = 8,
  parameter int DT_W     = 1,
  parameter int MAX_SKIP = 15,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic             fb_low,
  input  logic             skip_en,
  output logic             phi1,
  output logic             phi2,
  output logic             active,
  output logic             skip_pulse,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int PER = 2 * (PH_W + DT_W);
  localparam int PCW = $clog2(PER);
  localparam int SCW = $clog2(MAX_SKIP + 1);

  localparam logic [PCW-1:0] PH_LAST = PCW'(PH_W - 1);
  localparam logic [PCW-1:0] DT_LAST = PCW'(DT_W - 1);
  localparam logic [PCW-1:0] SK_LAST = PCW'(PER - 1);
  localparam logic [SCW-1:0] SK_MAX  = SCW'(MAX_SKIP);

  typedef enum logic [2:0] {IDLE, PH1, DT1, PH2, DT2, SKIP} state_t;

  state_t         state;
  logic [PCW-1:0] ph_cnt;
  logic [SCW-1:0] skip_cnt;

  assign active = (state != IDLE);

  // Phase sequencer. Phase outputs are registered alongside the state so they
  // never glitch. fb_low/skip_en/en are only consulted at the decision clock
  // (last DT2 or last SKIP clock), except en, which also aborts a SKIP.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state      <= IDLE;
      ph_cnt     <= '0;
      skip_cnt   <= '0;
      phi1       <= 1'b0;
      phi2       <= 1'b0;
      skip_pulse <= 1'b0;
      cycle_cnt  <= '0;
    end else begin
      skip_pulse <= 1'b0;
      case (state)
        IDLE: begin
          ph_cnt <= '0;
          if (en) begin
            state <= PH1;
            phi1  <= 1'b1;
          end
        end
        PH1: begin
          if (ph_cnt == PH_LAST) begin
            state  <= DT1;
            phi1   <= 1'b0;
            ph_cnt <= '0;
          end else begin
            ph_cnt <= ph_cnt + PCW'(1);
          end
        end
        DT1: begin
          if (ph_cnt == DT_LAST) begin
            state  <= PH2;
            phi2   <= 1'b1;
            ph_cnt <= '0;
          end else begin
            ph_cnt <= ph_cnt + PCW'(1);
          end
        end
        PH2: begin
          if (ph_cnt == PH_LAST) begin
            state  <= DT2;
            phi2   <= 1'b0;
            ph_cnt <= '0;
          end else begin
            ph_cnt <= ph_cnt + PCW'(1);
          end
        end
        DT2: begin
          if (ph_cnt == DT_LAST) begin
            // Period completed; the skip run restarts from zero, so a skip
            // is always allowed here (MAX_SKIP >= 1).
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            skip_cnt  <= '0;
            ph_cnt    <= '0;
            if (!en) begin
              state <= IDLE;
            end else if (skip_en && !fb_low) begin
              state      <= SKIP;
              skip_cnt   <= SCW'(1);
              skip_pulse <= 1'b1;
            end else begin
              state <= PH1;
              phi1  <= 1'b1;
            end
          end else begin
            ph_cnt <= ph_cnt + PCW'(1);
          end
        end
        SKIP: begin
          if (!en) begin
            // Nothing is in flight during a skip, so shut down at once.
            state    <= IDLE;
            skip_cnt <= '0;
            ph_cnt   <= '0;
          end else if (ph_cnt == SK_LAST) begin
            ph_cnt <= '0;
            if (skip_en && !fb_low && (skip_cnt < SK_MAX)) begin
              state      <= SKIP;
              skip_cnt   <= skip_cnt + SCW'(1);
              skip_pulse <= 1'b1;
            end else begin
              // Demand or forced refresh after MAX_SKIP idle periods.
              state <= PH1;
              phi1  <= 1'b1;
            end
          end else begin
            ph_cnt <= ph_cnt + PCW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          phi1   <= 1'b0;
          phi2   <= 1'b0;
          ph_cnt <= '0;
        end
      endcase
    end
  end

endmodule
